// File: rtl/freq_meter_pkg.sv
// Shared constants, window-state type and width helper for the frequency meter.
package freq_meter_pkg;
  localparam int DEF_GATE_CYCLES = 1600;
  localparam int DEF_COUNT_W     = 16;

  typedef enum logic {WIN_DISCARD = 1'b0, WIN_MEASURE = 1'b1} win_state_t;

  // Bits needed to hold 0..n-1 (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/freq_meter_if.sv
// Result handshake bundle: measured count, status flags and valid/ready.
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) ();
  logic [COUNT_W-1:0] meas_count;
  logic               meas_ovf;
  logic               meas_overrun;
  logic               meas_valid;
  logic               meas_ready;

  modport master (output meas_count, meas_ovf, meas_overrun, meas_valid, input meas_ready);
  modport slave  (input meas_count, meas_ovf, meas_overrun, meas_valid, output meas_ready);
endinterface

// File: rtl/freq_meter_sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector on the synchronized level.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);
  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
endmodule

// File: rtl/freq_meter.sv
// Gated edge counter reporting sig_in edges per GATE_CYCLES window over valid/ready.
// Optional lock detection is built when FREQ_METER_LOCK_EN is defined.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int F_CLK        = 16000000,
  parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int COUNT_W      = DEF_COUNT_W,
  parameter int EXPECT_COUNT = 100,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           sig_in,
  freq_meter_if.master   meas,
  output logic           locked
);
  localparam int                 GW        = cnt_bits(GATE_CYCLES);
  localparam logic [GW-1:0]      GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  logic               rise;
  logic [GW-1:0]      gate;
  logic [COUNT_W-1:0] cnt, fin_cnt;
  logic               ovf, fin_ovf;
  logic               terminal, load;
  win_state_t         win_st, win_nxt;

  sync_edge_detect u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .rise     (rise)
  );

  assign terminal = en && (gate == GATE_LAST);
  // Window totals include an edge landing on the terminal cycle itself.
  assign fin_cnt  = (rise && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
  assign fin_ovf  = ovf | (rise && (cnt == CNT_MAX));

  always_ff @(posedge clk) begin
    if (reset || !en || terminal) begin
      gate <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      gate <= gate + 1'b1;
      cnt  <= fin_cnt;
      ovf  <= fin_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) win_st <= WIN_DISCARD;
    else       win_st <= win_nxt;
  end

  // The window following reset or an en rise only primes the synchronizer.
  always_comb begin
    win_nxt = win_st;
    load    = 1'b0;
    if (!en) begin
      win_nxt = WIN_DISCARD;
    end else if (terminal) begin
      win_nxt = WIN_MEASURE;
      load    = (win_st == WIN_MEASURE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meas.meas_count   <= '0;
      meas.meas_ovf     <= 1'b0;
      meas.meas_overrun <= 1'b0;
      meas.meas_valid   <= 1'b0;
    end else if (load) begin
      meas.meas_count   <= fin_cnt;
      meas.meas_ovf     <= fin_ovf;
      meas.meas_valid   <= 1'b1;
      meas.meas_overrun <= meas.meas_valid & ~meas.meas_ready;
    end else if (meas.meas_valid && meas.meas_ready) begin
      meas.meas_valid   <= 1'b0;
      meas.meas_overrun <= 1'b0;
    end
  end

`ifdef FREQ_METER_LOCK_EN
  localparam int                 LW     = cnt_bits(LOCK_WINDOWS + 1);
  localparam logic [LW-1:0]      LOCK_N = LOCK_WINDOWS[LW-1:0];
  localparam logic [COUNT_W:0]   EXP_V  = EXPECT_COUNT[COUNT_W:0];
  localparam logic [COUNT_W:0]   TOL_V  = TOL[COUNT_W:0];

  logic [COUNT_W:0] diff;
  logic             in_range;
  logic [LW-1:0]    lock_cnt;
  logic             unused_params;

  assign unused_params = F_CLK[0];

  always_comb begin
    diff     = ({1'b0, fin_cnt} >= EXP_V) ? {1'b0, fin_cnt} - EXP_V : EXP_V - {1'b0, fin_cnt};
    in_range = !fin_ovf && (diff <= TOL_V);
  end

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (load) begin
      if (in_range) begin
        if (lock_cnt != LOCK_N) lock_cnt <= lock_cnt + 1'b1;
        locked <= (lock_cnt >= LOCK_N - 1'b1);
      end else begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end
`else
  logic unused_params;

  assign unused_params = ^{F_CLK[0], EXPECT_COUNT[0], TOL[0], LOCK_WINDOWS[0]};
  assign locked        = 1'b0;
`endif
endmodule
